// File: rtl/dac_frame_fifo.sv
// Stereo frame FIFO feeding the DAC serializer: buffers L/R frames from the mixer
// and, on each pop, delivers one frame as a left word then a right word (silence on underrun).
module dac_frame_fifo #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      frame_l_i,
    input  logic [WIDTH-1:0]      frame_r_i,
    input  logic                  frame_valid_i,
    output logic                  frame_ready_o,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  lrck_o,
    output logic                  ack_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  underrun_o,
    output logic [15:0]           underrun_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      WORD_ZERO = {WIDTH{1'b0}};
    localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_L = 2'd1,
        SEND_R = 2'd2
    } state_t;

    logic [2*WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    state_t                state_r;
    logic [WIDTH-1:0]      data_r;
    logic [WIDTH-1:0]      right_hold_r;
    logic                  lrck_r;
    logic                  ack_r;
    logic                  underrun_r;
    logic [15:0]           underrun_cnt_r;

    logic                  ready_s;
    logic                  empty_s;
    logic                  wr_en_s;
    logic                  pop_en_s;
    logic                  rd_en_s;
    logic [2*WIDTH-1:0]    head_s;

    // Handshake decode; readiness looks at the stored level only, so a full FIFO
    // refuses a write even when a frame retires on the same edge.
    always_comb begin
        ready_s  = ~rst & (level_r != LVL_FULL);
        empty_s  = (level_r == LVL_ZERO);
        wr_en_s  = frame_valid_i & ready_s;
        pop_en_s = ~rst & pop_i & (state_r == IDLE);
        rd_en_s  = pop_en_s & ~empty_s;
        if (empty_s) begin
            head_s = {(2*WIDTH){1'b0}};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    // Frame storage, written on an accepted handshake.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {frame_l_i, frame_r_i};
        end
    end

    // Pointers wrap naturally; occupancy is tracked by an explicit level counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Delivery FSM: the left word is loaded on the pop edge, the right word one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            data_r         <= WORD_ZERO;
            right_hold_r   <= WORD_ZERO;
            lrck_r         <= 1'b0;
            ack_r          <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r      <= 1'b0;
                    underrun_r <= 1'b0;
                    if (pop_en_s) begin
                        state_r      <= SEND_L;
                        data_r       <= head_s[2*WIDTH-1:WIDTH];
                        right_hold_r <= head_s[WIDTH-1:0];
                        lrck_r       <= 1'b0;
                        ack_r        <= 1'b1;
                        underrun_r   <= empty_s;
                        if (empty_s && (underrun_cnt_r != CNT_MAX)) begin
                            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
                        end
                    end
                end
                SEND_L: begin
                    state_r    <= SEND_R;
                    data_r     <= right_hold_r;
                    lrck_r     <= 1'b1;
                    ack_r      <= 1'b1;
                    underrun_r <= 1'b0;
                end
                SEND_R: begin
                    state_r    <= IDLE;
                    ack_r      <= 1'b0;
                    underrun_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ack_r      <= 1'b0;
                    underrun_r <= 1'b0;
                end
            endcase
        end
    end

    assign frame_ready_o    = ready_s;
    assign data_o           = data_r;
    assign lrck_o           = lrck_r;
    assign ack_o            = ack_r;
    assign level_o          = level_r;
    assign underrun_o       = underrun_r;
    assign underrun_count_o = underrun_cnt_r;

endmodule

// File: tb/tb_dac_frame_fifo.sv
// Self-checking bench for dac_frame_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model of frames and scheduled output words.
module tb_dac_frame_fifo;

    localparam int W = 24;
    localparam int DL = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  frame_l_i, frame_r_i;
    logic          frame_valid_i, frame_ready_o, pop_i;
    logic [W-1:0]  data_o;
    logic          lrck_o, ack_o, underrun_o;
    logic [DL:0]   level_o;
    logic [15:0]   underrun_count_o;

    int errors = 0;
    int checks = 0;

    // reference model: stored frames and the words scheduled for the output
    logic [2*W-1:0] q[$];
    logic [W+1:0]   pend[$];   // {data, lrck, underrun}
    logic [15:0]    m_cnt;
    logic [W-1:0]   m_last_data;
    logic           m_last_lr;
    logic           e_ack, e_lr, e_und;
    logic [W-1:0]   e_data;
    int             e_level;
    logic [2*W-1:0] written[32];

    dac_frame_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst),
        .frame_l_i(frame_l_i), .frame_r_i(frame_r_i),
        .frame_valid_i(frame_valid_i), .frame_ready_o(frame_ready_o),
        .pop_i(pop_i), .data_o(data_o), .lrck_o(lrck_o), .ack_o(ack_o),
        .level_o(level_o), .underrun_o(underrun_o), .underrun_count_o(underrun_count_o)
    );

    always #5 clk = ~clk;

    // One clock edge for DUT and model; returns at the following negedge.
    task automatic tick();
        logic acc_pop, acc_wr, und;
        logic [2*W-1:0] fr;
        acc_pop = !rst && pop_i && (pend.size() == 0);
        acc_wr  = !rst && frame_valid_i && (q.size() != DEPTH);
        @(posedge clk);
        if (rst) begin
            q.delete(); pend.delete();
            m_cnt = 16'h0; m_last_data = '0; m_last_lr = 1'b0;
        end else begin
            if (pend.size() != 0) void'(pend.pop_front());
            if (acc_pop) begin
                if (q.size() != 0) begin fr = q.pop_front(); und = 1'b0; end
                else begin
                    fr = '0; und = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
                end
                pend.push_back({fr[2*W-1:W], 1'b0, und});
                pend.push_back({fr[W-1:0], 1'b1, 1'b0});
            end
            if (acc_wr) q.push_back({frame_l_i, frame_r_i});
        end
        if (pend.size() != 0) begin
            e_ack = 1'b1; e_data = pend[0][W+1:2]; e_lr = pend[0][1]; e_und = pend[0][0];
            m_last_data = e_data; m_last_lr = e_lr;
        end else begin
            e_ack = 1'b0; e_und = 1'b0; e_data = m_last_data; e_lr = m_last_lr;
        end
        e_level = q.size();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_valid_i = 1'b0; pop_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_frame(input logic [2*W-1:0] f);
        frame_l_i = f[2*W-1:W]; frame_r_i = f[W-1:0]; frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_valid_i = 1'b1; pop_i = 1'b1;
        frame_l_i = 24'h111111; frame_r_i = 24'h222222;
        tick(); tick();
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level_o); end
        checks++; if ({ack_o, lrck_o, underrun_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {ack_o, lrck_o, underrun_o}); end
        checks++; if (data_o !== 24'h0) begin errors++; $display("FAIL reset_data: got %h exp 000000", data_o); end
        checks++; if (underrun_count_o !== 16'h0) begin errors++; $display("FAIL reset_count: got %h exp 0000", underrun_count_o); end
        checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", frame_ready_o); end
        frame_valid_i = 1'b0; pop_i = 1'b0; rst = 1'b0;
        #1;
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b exp 1", frame_ready_o); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        write_frame({24'h123456, 24'hABCDEF});
        checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL basic_level1: got %0d exp 1", level_o); end
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        checks++; if ({ack_o, lrck_o, data_o} !== {1'b1, 1'b0, 24'h123456}) begin errors++; $display("FAIL basic_left: got ack=%b lr=%b %h exp ack=1 lr=0 123456", ack_o, lrck_o, data_o); end
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL basic_level0: got %0d exp 0", level_o); end
        tick();
        checks++; if ({ack_o, lrck_o, data_o} !== {1'b1, 1'b1, 24'hABCDEF}) begin errors++; $display("FAIL basic_right: got ack=%b lr=%b %h exp ack=1 lr=1 abcdef", ack_o, lrck_o, data_o); end
        tick();
        checks++; if ({ack_o, data_o} !== {1'b0, 24'hABCDEF}) begin errors++; $display("FAIL basic_idle_hold: got ack=%b %h exp ack=0 abcdef", ack_o, data_o); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) written[i] = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
        for (int i = 0; i < DEPTH; i++) write_frame(written[i]);
        checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", frame_ready_o); end
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_level: got %0d exp 16", level_o); end
        write_frame({24'hDEAD00, 24'hBEEF00});
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_17th: got %0d exp 16", level_o); end
        for (int i = 0; i < DEPTH; i++) begin
            pop_i = 1'b1; tick(); pop_i = 1'b0;
            checks++; if (data_o !== written[i][2*W-1:W] || ack_o !== 1'b1) begin errors++; $display("FAIL wrap_left[%0d]: got %h exp %h", i, data_o, written[i][2*W-1:W]); end
            tick();
            checks++; if (data_o !== written[i][W-1:0] || lrck_o !== 1'b1) begin errors++; $display("FAIL wrap_right[%0d]: got %h exp %h", i, data_o, written[i][W-1:0]); end
            tick();
        end
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL wrap_drained: got %0d exp 0", level_o); end
    endtask

    task automatic test_underrun();
        do_reset();
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        checks++; if ({ack_o, lrck_o, underrun_o, data_o} !== {3'b101, 24'h0}) begin errors++; $display("FAIL und_left: got ack=%b lr=%b und=%b %h exp 1 0 1 000000", ack_o, lrck_o, underrun_o, data_o); end
        checks++; if (underrun_count_o !== 16'd1) begin errors++; $display("FAIL und_count1: got %h exp 0001", underrun_count_o); end
        tick();
        checks++; if ({ack_o, lrck_o, underrun_o, data_o} !== {3'b110, 24'h0}) begin errors++; $display("FAIL und_right: got ack=%b lr=%b und=%b %h exp 1 1 0 000000", ack_o, lrck_o, underrun_o, data_o); end
        tick();
        force dut.underrun_cnt_r = 16'hFFFE;
        #1;
        release dut.underrun_cnt_r;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            pop_i = 1'b1; tick(); pop_i = 1'b0;
            checks++; if (underrun_count_o !== 16'hFFFF || underrun_o !== 1'b1) begin errors++; $display("FAIL und_saturate[%0d]: got %h und=%b exp ffff und=1", k, underrun_count_o, underrun_o); end
            tick(); tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            written[i] = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
            write_frame(written[i]);
        end
        frame_l_i = 24'h0BAD01; frame_r_i = 24'h0BAD02; frame_valid_i = 1'b1; pop_i = 1'b1;
        tick(); frame_valid_i = 1'b0; pop_i = 1'b0;
        checks++; if (level_o !== 5'd15) begin errors++; $display("FAIL full_simul_level: got %0d exp 15", level_o); end
        tick(); tick();
        for (int i = 1; i < 8; i++) begin pop_i = 1'b1; tick(); pop_i = 1'b0; tick(); tick(); end
        checks++; if (level_o !== 5'd8) begin errors++; $display("FAIL mid_level_pre: got %0d exp 8", level_o); end
        written[DEPTH] = {24'h5A5A5A, 24'hA5A5A5};
        frame_l_i = 24'h5A5A5A; frame_r_i = 24'hA5A5A5; frame_valid_i = 1'b1; pop_i = 1'b1;
        tick(); frame_valid_i = 1'b0; pop_i = 1'b0;
        checks++; if (level_o !== 5'd8) begin errors++; $display("FAIL mid_simul_level: got %0d exp 8", level_o); end
        checks++; if (data_o !== written[8][2*W-1:W]) begin errors++; $display("FAIL mid_simul_data: got %h exp %h", data_o, written[8][2*W-1:W]); end
        tick(); tick();
        for (int i = 9; i <= DEPTH; i++) begin
            pop_i = 1'b1; tick(); pop_i = 1'b0;
            checks++; if (data_o !== written[i][2*W-1:W]) begin errors++; $display("FAIL mid_order[%0d]: got %h exp %h", i, data_o, written[i][2*W-1:W]); end
            tick(); tick();
        end
    endtask

    task automatic test_pop_ignored();
        int acks;
        do_reset();
        write_frame({24'h000A01, 24'h000A02});
        write_frame({24'h000B01, 24'h000B02});
        acks = 0;
        pop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (ack_o === 1'b1) acks++; end
        pop_i = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); if (ack_o === 1'b1) acks++; end
        checks++; if (acks != 2) begin errors++; $display("FAIL busy_pop_acks: got %0d exp 2", acks); end
        checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL busy_pop_level: got %0d exp 1", level_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_frame({24'h777777, 24'h888888});
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        checks++; if (data_o !== 24'h777777) begin errors++; $display("FAIL rmid_left: got %h exp 777777", data_o); end
        rst = 1'b1; tick();
        checks++; if ({ack_o, lrck_o, underrun_o, data_o, level_o} !== {3'b000, 24'h0, 5'd0}) begin errors++; $display("FAIL rmid_outputs: got ack=%b lr=%b und=%b %h lvl=%0d exp all 0", ack_o, lrck_o, underrun_o, data_o, level_o); end
        checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b exp 0", frame_ready_o); end
        rst = 1'b0; tick();
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rmid_no_right: got %b exp 0", ack_o); end
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        checks++; if ({ack_o, underrun_o, data_o} !== {2'b11, 24'h0}) begin errors++; $display("FAIL rmid_underrun: got ack=%b und=%b %h exp 1 1 000000", ack_o, underrun_o, data_o); end
        checks++; if (underrun_count_o !== 16'd1) begin errors++; $display("FAIL rmid_count: got %h exp 0001", underrun_count_o); end
        tick(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            frame_valid_i = ($urandom_range(0, 2) != 0);
            pop_i = ($urandom_range(0, 3) == 0);
            frame_l_i = $urandom_range(0, 24'hFFFFFF);
            frame_r_i = $urandom_range(0, 24'hFFFFFF);
            tick();
            checks++;
            if (ack_o !== e_ack || lrck_o !== e_lr || data_o !== e_data || underrun_o !== e_und ||
                level_o !== e_level[DL:0] || underrun_count_o !== m_cnt) begin
                errors++;
                $display("FAIL rand[%0d]: got ack=%b lr=%b d=%h und=%b lvl=%0d cnt=%h exp ack=%b lr=%b d=%h und=%b lvl=%0d cnt=%h",
                         n, ack_o, lrck_o, data_o, underrun_o, level_o, underrun_count_o,
                         e_ack, e_lr, e_data, e_und, e_level, m_cnt);
            end
            checks++;
            if (frame_ready_o !== (!rst && (q.size() != DEPTH))) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b exp %b", n, frame_ready_o, (!rst && (q.size() != DEPTH)));
            end
        end
        rst = 1'b0; frame_valid_i = 1'b0; pop_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_valid_i = 1'b0; pop_i = 1'b0;
        frame_l_i = '0; frame_r_i = '0;
        m_cnt = 16'h0; m_last_data = '0; m_last_lr = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_wrap();
        test_underrun();
        test_simultaneous();
        test_pop_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
